spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Byte-wide SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, one CS line.
//  Drives SCK/CS/MOSI toward the team's SPI slave block and captures MISO.
//  Intended for same-clock bench loopback and for the host side of the SPI link.
//  One start pulse sends one byte and returns one received byte.
// PARAMETERS
//  HALF_DIV  8  clk cycles per SCK half-period; min 4, or min 6 with MISO sync
//  CS_SETUP  4  clk cycles from CS fall to first SCK rise; min 4
//  CS_HOLD   4  clk cycles from last SCK fall to CS rise; min 1
//  CS_IDLE   4  clk cycles CS held high after a transfer before busy drops; min 1
// PORTS
//  clk      in   1  system clock; all logic on posedge
//  rst      in   1  synchronous reset, active-high
//  start    in   1  begin a transfer; sampled only while busy=0
//  tx_data  in   8  byte to send; latched on the accepted start cycle
//  busy     out  1  high while a transfer, including the CS_IDLE gap, is in progress
//  done     out  1  one-cycle pulse when the transfer completes; rx_data valid
//  rx_data  out  8  last received byte; held until the next done
//  SCK      out  1  serial clock, idle low
//  CS       out  1  chip select, active-low, idle high
//  MOSI     out  1  serial data out
//  MISO     in   1  serial data in
// BEHAVIOUR
//  Reset: SCK=0, CS=1, MOSI=0, busy=0, done=0, rx_data=0x00, FSM=IDLE.
//  All outputs are registered. Counters are sized for the largest parameter.
//  FSM states:
//   IDLE:  on start (cycle 0), latch tx_data into the shift reg and go to SETUP.
//   SETUP: from cycle 1, CS=0, MOSI=tx[7], busy=1.
//          After CS_SETUP cycles, go to XFER.
//   XFER:  SCK rise k (k=0..7) at cycle 1+CS_SETUP+2k*HALF_DIV.
//          SCK fall k at rise k + HALF_DIV.
//          On rise k, shift MISO into rx_shift[7-k].
//          On falls 0..6, MOSI takes the next bit. On fall 7, MOSI holds.
//          After fall 7, go to HOLD.
//   HOLD:  SCK=0, CS=0 for CS_HOLD cycles. Then CS=1, rx_data<=rx_shift,
//          done=1 for 1 cycle, go to GAP.
//   GAP:   CS=1, busy=1 for CS_IDLE cycles, then busy=0 and go to IDLE.
//  Latency: done at cycle 1+CS_SETUP+15*HALF_DIV+CS_HOLD after start.
//   Defaults: done at 129, busy low at 133.
//  Start while busy=1, including the done cycle and GAP, is ignored and not queued.
//  Start on the first cycle busy=0 is accepted.
//  tx_data changes after start have no effect on the byte in flight.
//  Reset mid-transfer: the next cycle shows the reset values.
//   No done pulse; rx_data returns to 0x00.
//  Reset has priority over start in the same cycle.
//  MOSI holds its last value between transfers. It changes only in SETUP/XFER.
// CONFIGURATION
//  SPI_MASTER_MISO_SYNC_EN defined: MISO passes through a 2-flop synchronizer
//   before sampling. The captured bit is the synchronized value at each rise.
//   This adds 2 cycles of input delay, so HALF_DIV must be >= 6.
//  Not defined: MISO is sampled directly on the rise cycle. HALF_DIV >= 4.
//  The slave updates MISO 3 clk cycles after SCK falls; the minimums cover this.
// TESTING
//  T1 rst=1 for 2 cycles -> SCK=0, CS=1, MOSI=0, busy=0, done=0, rx_data=0x00.
//  T2 defaults, MISO tied to MOSI, start with tx_data=0xA5 ->
//     MOSI at rises 1,0,1,0,0,1,0,1; CS low cycles 1..128;
//     done at 129 with rx_data=0xA5; busy low at 133.
//  T3 paired with the SPI slave on the same clk; slave tx loaded 0x81 in SETUP;
//     master tx_data=0x5A -> master rx_data=0x81;
//     slave rx_read_data=0x5A with DATR=1.
//  T4 start pulsed at cycles 40, 129 and 131 -> all ignored;
//     start at 133 is accepted, CS falls at 134.
//  T5 rst pulsed at cycle 60 of a 0xFF transfer ->
//     cycle 61 shows CS=1, SCK=0, busy=0; no done; a following transfer is correct.
//  T6 SPI_MASTER_MISO_SYNC_EN defined, HALF_DIV=6, T3 repeated -> identical results;
//     done at 1+4+90+4=99.

Source files
------------

// File: rtl/spi_master_if.sv
// SPI initiator bus: host handshake (start/tx_data/busy/done/rx_data) plus the
// four SPI wires (SCK/CS/MOSI/MISO).
// Modports:
//   master - the spi_master block: drives busy/done/rx_data/SCK/CS/MOSI,
//            reads start/tx_data/MISO.
//   slave  - the peer side (host logic and SPI target): the mirror image.
interface spi_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       SCK;
  logic       CS;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, tx_data, MISO,
    output busy, done, rx_data, SCK, CS, MOSI
  );

  modport slave (
    output start, tx_data, MISO,
    input  busy, done, rx_data, SCK, CS, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, single CS.
// One accepted start sends tx_data and returns the received byte on rx_data
// with a one-cycle done pulse.
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - synchronous reset, active-high
//   bus  - spi_master_if.master: start/tx_data in, busy/done/rx_data out,
//          SCK/CS/MOSI out, MISO in
// Parameters: HALF_DIV (clk per SCK half period), CS_SETUP, CS_HOLD, CS_IDLE.
// Option: define SPI_MASTER_MISO_SYNC_EN to pass MISO through a 2-flop
//   synchronizer before sampling (requires HALF_DIV >= 6).
module spi_master #(
  parameter int unsigned HALF_DIV = 8,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam int unsigned MAX_A   = (HALF_DIV > CS_SETUP) ? HALF_DIV : CS_SETUP;
  localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // Counter only ever holds values up to CNT_MAX-1.
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             sck_q, sck_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_zero;
  logic             rise_cyc;
  logic             miso_smp;

  assign cnt_zero = (cnt_q == '0);
  // First cycle of an SCK high half: the bit is captured at the end of it.
  assign rise_cyc = (state_q == S_XFER) && sck_q && (cnt_q == CNT_W'(HALF_DIV - 1));

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic miso_s1_q, miso_s2_q;

  // Two-flop synchronizer on the incoming serial data.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= bus.MISO;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign miso_smp = miso_s2_q;
`else
  assign miso_smp = bus.MISO;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SETUP;
      S_SETUP: if (cnt_zero) state_d = S_XFER;
      S_XFER:  if (cnt_zero && sck_q && (bit_q == 3'd7)) state_d = S_HOLD;
      S_HOLD:  if (cnt_zero) state_d = S_GAP;
      S_GAP:   if (cnt_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath; they take effect on
  // the same edge as the state change, so each output lines up with its state.
  always_comb begin
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d   = CNT_W'(CS_SETUP - 1);
          bit_d   = 3'd0;
          tx_sh_d = bus.tx_data;
          rx_sh_d = 8'h00;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = bus.tx_data[7];
        end
      end

      S_SETUP: begin
        if (cnt_zero) begin
          cnt_d = CNT_W'(HALF_DIV - 1);
          sck_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_XFER: begin
        if (rise_cyc) rx_sh_d = {rx_sh_q[6:0], miso_smp};
        if (cnt_zero) begin
          if (sck_q) begin
            // Falling edge: advance MOSI except after the last bit; the fall
            // cycle of bit 7 is already the first CS hold cycle.
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              cnt_d = CNT_W'(CS_HOLD - 1);
            end else begin
              cnt_d   = CNT_W'(HALF_DIV - 1);
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
              mosi_d  = tx_sh_q[6];
            end
          end else begin
            sck_d = 1'b1;
            bit_d = bit_q + 3'd1;
            cnt_d = CNT_W'(HALF_DIV - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_zero) begin
          cnt_d     = CNT_W'(CS_IDLE - 1);
          cs_d      = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_zero) busy_d = 1'b0;
        else          cnt_d  = cnt_q - CNT_W'(1);
      end

      default: begin
        sck_d  = 1'b0;
        cs_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      tx_sh_q   <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_data_q <= 8'h00;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.SCK     = sck_q;
  assign bus.CS      = cs_q;
  assign bus.MOSI    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: reset values, loopback transfers, a
// behavioural SPI target, ignored starts while busy, and mid-transfer reset.
module tb_spi_master;

`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int unsigned HALF_DIV = 6;
`else
  localparam int unsigned HALF_DIV = 8;
`endif
  localparam int DONE_CYC = 1 + 4 + 15 * HALF_DIV + 4;
  localparam int IDLE_CYC = DONE_CYC + 4;

  logic clk = 1'b0;
  logic rst;
  logic loop_en;

  spi_master_if ifc ();

  spi_master #(
    .HALF_DIV (HALF_DIV),
    .CS_SETUP (4),
    .CS_HOLD  (4),
    .CS_IDLE  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Behavioural target: presents its byte MSB first, updates MISO three
  // clocks after each SCK fall, captures MOSI on SCK rises.
  logic [7:0] slv_tx, slv_sh, slv_rx;
  logic       slv_miso, slv_sck_p;
  logic [1:0] slv_pend;

  always @(posedge clk) begin
    slv_sck_p <= ifc.SCK;
    slv_pend  <= {slv_pend[0], slv_sck_p & ~ifc.SCK};
    if (ifc.CS) begin
      slv_sh   <= slv_tx;
      slv_miso <= slv_tx[7];
    end else if (slv_pend[1]) begin
      slv_sh   <= {slv_sh[6:0], 1'b0};
      slv_miso <= slv_sh[6];
    end
    if (!ifc.CS && ifc.SCK && !slv_sck_p) slv_rx <= {slv_rx[6:0], ifc.MOSI};
  end

  assign ifc.MISO = loop_en ? ifc.MOSI : slv_miso;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer starting in the current cycle (cycle 0). Returns at the first
  // cycle busy should be low. With pulses set, start is also raised at cycles
  // 40, DONE_CYC and DONE_CYC+2, which must all be ignored.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_rx, input bit pulses);
    int cs_first = -1;
    int cs_last  = -1;
    int done_cyc = -1;
    int busy_low = -1;
    int n_done   = 0;
    int rises    = 0;
    logic [7:0] mosi_bits = 8'h00;
    logic [7:0] rx_got    = 8'h00;
    logic sck_p = 1'b0;

    check("cs_high_at_start", 32'(ifc.CS), 32'd1);
    ifc.tx_data = tx;
    ifc.start   = 1'b1;
    for (int c = 1; c <= IDLE_CYC; c++) begin
      @(posedge clk); #1;
      ifc.start   = 1'b0;
      ifc.tx_data = ~tx;
      if (pulses && (c == 40 || c == DONE_CYC || c == DONE_CYC + 2)) ifc.start = 1'b1;
      if (!ifc.CS) begin
        if (cs_first < 0) cs_first = c;
        cs_last = c;
      end
      if (ifc.SCK && !sck_p) begin
        mosi_bits = {mosi_bits[6:0], ifc.MOSI};
        rises++;
      end
      sck_p = ifc.SCK;
      if (ifc.done) begin
        n_done++;
        done_cyc = c;
        rx_got   = ifc.rx_data;
      end
      if (!ifc.busy && busy_low < 0) busy_low = c;
    end
    check("cs_first_low", 32'(cs_first), 32'd1);
    check("cs_last_low", 32'(cs_last), 32'(DONE_CYC - 1));
    check("sck_rises", 32'(rises), 32'd8);
    check("mosi_at_rises", 32'(mosi_bits), 32'(tx));
    check("done_count", 32'(n_done), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'(DONE_CYC));
    check("rx_at_done", 32'(rx_got), 32'(exp_rx));
    check("busy_low_cycle", 32'(busy_low), 32'(IDLE_CYC));
    check("rx_held", 32'(ifc.rx_data), 32'(exp_rx));
    check("mosi_idle_hold", 32'(ifc.MOSI), 32'(tx[0]));
  endtask

  initial begin
    int dones;
    int busies;
    rst         = 1'b1;
    loop_en     = 1'b1;
    ifc.start   = 1'b0;
    ifc.tx_data = 8'h00;
    slv_tx      = 8'h81;
    slv_sh      = 8'h00;
    slv_rx      = 8'h00;
    slv_miso    = 1'b0;
    slv_sck_p   = 1'b0;
    slv_pend    = 2'b00;

    // T1: reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_sck", 32'(ifc.SCK), 32'd0);
    check("rst_cs", 32'(ifc.CS), 32'd1);
    check("rst_mosi", 32'(ifc.MOSI), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_rx", 32'(ifc.rx_data), 32'd0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // T2: loopback 0xA5
    loop_en = 1'b1;
    xfer(8'hA5, 8'hA5, 1'b0);

    // T3: against the behavioural target
    loop_en = 1'b0;
    slv_tx  = 8'h81;
    xfer(8'h5A, 8'h81, 1'b0);
    check("slave_rx", 32'(slv_rx), 32'h5A);

    // T4: starts while busy ignored; back-to-back start accepted
    loop_en = 1'b1;
    xfer(8'h3C, 8'h3C, 1'b1);
    xfer(8'hC3, 8'hC3, 1'b0);

    // T5: reset in cycle 60 of a 0xFF transfer
    ifc.tx_data = 8'hFF;
    ifc.start   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      ifc.start = 1'b0;
    end
    check("pre_rst_cs_low", 32'(ifc.CS), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_cs", 32'(ifc.CS), 32'd1);
    check("mid_rst_sck", 32'(ifc.SCK), 32'd0);
    check("mid_rst_busy", 32'(ifc.busy), 32'd0);
    check("mid_rst_done", 32'(ifc.done), 32'd0);
    check("mid_rst_rx", 32'(ifc.rx_data), 32'd0);
    check("mid_rst_mosi", 32'(ifc.MOSI), 32'd0);
    dones  = 0;
    busies = 0;
    for (int c = 0; c < DONE_CYC + 10; c++) begin
      @(posedge clk); #1;
      if (ifc.done) dones++;
      if (ifc.busy) busies++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);
    check("no_busy_after_rst", 32'(busies), 32'd0);
    xfer(8'h96, 8'h96, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
